// File: rtl/ternary_mvm_core.sv
// ternary_mvm_core
//   Parametrised ternary matrix-vector engine.
//   - LOAD streams an OUT_LEN x IN_LEN matrix of 2-bit ternary weights.
//     Codes are 01=+1, 11=-1, 00/10=0, and the lowest element sits in the LSBs.
//   - MULT clears the accumulators, then takes IN_LEN/LANES activation beats.
//     Every beat updates all rows in parallel.
//   - The OUT_LEN results then drain through a valid/ready port, row 0 first.
//   Optional feature: define OUT_SAT_EN to saturate each accumulate step.
//   A row that clamps stays clamped until the next MULT clears it. Without
//   the macro, sums wrap modulo 2^ACC_W.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/cmd_op    command strobe and opcode (1=LOAD, 2=MULT, others ignored)
//   cmd_ready           high only while idle
//   abort               return to idle next cycle from any state
//   in_valid/in_data    weight beat (LOAD) or activation beat (MULT)
//   in_ready            high in LOAD and ACC
//   out_valid/out_ready result handshake
//   out_data/out_row    signed result and its row index; zero outside DRAIN
//   out_last            high with the final row
//   busy                high whenever not idle
module ternary_mvm_core #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8,
    parameter int ACT_W   = 8,
    parameter int BUS_W   = 16,
    parameter int ACC_W   = 12,
    localparam int ROW_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    output logic                    cmd_ready,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [BUS_W-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [ROW_W-1:0]        out_row,
    output logic                    out_last,
    output logic                    busy
);

    localparam int LANES      = BUS_W / ACT_W;
    localparam int W_BITS     = 2 * IN_LEN * OUT_LEN;
    localparam int LOAD_BEATS = W_BITS / BUS_W;
    localparam int ACC_BEATS  = IN_LEN / LANES;
    localparam int MAX_A      = (LOAD_BEATS > ACC_BEATS) ? LOAD_BEATS : ACC_BEATS;
    localparam int MAX_CNT    = (MAX_A > OUT_LEN) ? MAX_A : OUT_LEN;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACC, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W_BITS-1:0]       w_q, w_d;
    logic signed [ACC_W-1:0] acc_q [OUT_LEN];
    logic signed [ACC_W-1:0] acc_d [OUT_LEN];
`ifdef OUT_SAT_EN
    logic [OUT_LEN-1:0]      sat_q, sat_d;
`endif

    logic cmd_fire, beat_fire, out_fire;
    logic load_last, acc_last, row_last;

    // Ternary weight times activation, one bit wider so that -(-2^(ACT_W-1)) fits.
    function automatic logic signed [ACT_W:0] tern_mul(input logic [1:0] w,
                                                       input logic signed [ACT_W-1:0] x);
        logic signed [ACT_W:0] xe;
        xe = {x[ACT_W-1], x};
        case (w)
            2'b01:   return xe;
            2'b11:   return -xe;
            default: return '0;
        endcase
    endfunction

`ifdef OUT_SAT_EN
    localparam int SUM_W = ((ACC_W > ACT_W) ? ACC_W : ACT_W + 1) + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Add in a width that cannot overflow, then clamp into the accumulator range.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACT_W:0] p,
                                                        output logic clamped);
        logic signed [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(p);
        clamped = 1'b0;
        if (s > SUM_W'(ACC_MAX)) begin
            clamped = 1'b1;
            return ACC_MAX;
        end
        if (s < SUM_W'(ACC_MIN)) begin
            clamped = 1'b1;
            return ACC_MIN;
        end
        return s[ACC_W-1:0];
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACT_W:0] p);
        return a + ACC_W'(p);
    endfunction
`endif

    // abort outranks every handshake, so a beat or command in its cycle is dropped.
    assign cmd_fire  = cmd_valid & cmd_ready & ~abort;
    assign beat_fire = in_valid & in_ready & ~abort;
    assign out_fire  = out_valid & out_ready & ~abort;
    assign load_last = (cnt_q == CNT_W'(LOAD_BEATS - 1));
    assign acc_last  = (cnt_q == CNT_W'(ACC_BEATS - 1));
    assign row_last  = (cnt_q == CNT_W'(OUT_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cmd_fire && cmd_op == 2'd1)      state_d = S_LOAD;
                         else if (cmd_fire && cmd_op == 2'd2) state_d = S_ACC;
                S_LOAD:  if (beat_fire && load_last)          state_d = S_IDLE;
                S_ACC:   if (beat_fire && acc_last)           state_d = S_DRAIN;
                S_DRAIN: if (out_fire && row_last)            state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        out_data  = '0;
        out_row   = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_LOAD, S_ACC: in_ready = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_last  = row_last;
                out_row   = cnt_q[ROW_W-1:0];
                out_data  = acc_q[cnt_q[ROW_W-1:0]];
            end
            default: ;
        endcase
    end

    // Beat counter, weight store and accumulators.
    always_comb begin
        logic signed [ACC_W-1:0] a;
        logic signed [ACT_W:0]   p;
        int                      base;
`ifdef OUT_SAT_EN
        logic                    s, c;
        s     = 1'b0;
        c     = 1'b0;
        sat_d = sat_q;
`endif
        a     = '0;
        p     = '0;
        base  = 0;
        cnt_d = cnt_q;
        w_d   = w_q;
        acc_d = acc_q;
        if (abort) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire && cmd_op == 2'd2) begin
                        acc_d = '{default: '0};
`ifdef OUT_SAT_EN
                        sat_d = '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (beat_fire) begin
                        base = int'(cnt_q) * BUS_W;
                        w_d[base +: BUS_W] = in_data;
                        cnt_d = load_last ? '0 : cnt_q + 1'b1;
                    end
                end
                S_ACC: begin
                    if (beat_fire) begin
                        for (int r = 0; r < OUT_LEN; r++) begin
                            a = acc_q[r];
`ifdef OUT_SAT_EN
                            s = sat_q[r];
`endif
                            for (int l = 0; l < LANES; l++) begin
                                base = 2 * (r * IN_LEN + int'(cnt_q) * LANES + l);
                                p = tern_mul(w_q[base +: 2], in_data[l*ACT_W +: ACT_W]);
`ifdef OUT_SAT_EN
                                // Once clamped, the row holds its rail value.
                                if (!s) begin
                                    a = sat_add(a, p, c);
                                    s = c;
                                end
`else
                                a = wrap_add(a, p);
`endif
                            end
                            acc_d[r] = a;
`ifdef OUT_SAT_EN
                            sat_d[r] = s;
`endif
                        end
                        cnt_d = acc_last ? '0 : cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) cnt_d = row_last ? '0 : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            w_q   <= '0;
            acc_q <= '{default: '0};
`ifdef OUT_SAT_EN
            sat_q <= '0;
`endif
        end else begin
            cnt_q <= cnt_d;
            w_q   <= w_d;
            acc_q <= acc_d;
`ifdef OUT_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

endmodule
